deadtime_gen: RTL and testbench
===============================

// Module: deadtime_gen
// PURPOSE
//  Three-phase dead-time insertion and gate-enable stage, directly downstream of the SPWM comparator.
//  Takes the upper-switch commands for legs a/b/c (Sau/Sbu/Scu from the comparator) and drives six registered gate signals.
//  Guarantees upper and lower switches of a leg are never on together, and both are off for DT clocks at every commutation.
//  Also provides enable gating and a latched over-current trip.
// PARAMETERS
//  DT    4  dead time in clk cycles; legal range 1..2**DTW-1
//  DTW   8  dead-time counter width
// PORTS
//  clk       in   1  system clock, shared with counter/spwm
//  res       in   1  asynchronous, active-high reset
//  en        in   1  gate enable; 0 forces all gates off
//  trip      in   1  fault input, active-high, sampled each clk
//  trip_clr  in   1  clears latched trip; honoured only while trip=0
//  cmd_a     in   1  leg a upper command (1 = upper on); lower is implied complement
//  cmd_b     in   1  leg b upper command
//  cmd_c     in   1  leg c upper command
//  Sau,Sal   out  1  leg a upper/lower gate, registered
//  Sbu,Sbl   out  1  leg b upper/lower gate, registered
//  Scu,Scl   out  1  leg c upper/lower gate, registered
//  tripped   out  1  latched trip status, registered
// BEHAVIOUR
//  - Reset (res=1, async): all six gates 0, tripped 0, every leg in state OFF, counters 0, cmd_q 0.
//  - Each cmd_x is registered once into cmd_q_x; the FSMs act only on cmd_q_x.
//  - Per-leg Moore FSM; gate outputs are a registered decode of the state:
//      OFF: both gates 0. Entered on reset, on en=0, or on tripped=1.
//           If en=1 and tripped=0: load cnt=DT-1 and go to DEAD_UP when cmd_q=1, DEAD_LO when cmd_q=0.
//      DEAD_UP: both gates 0; cnt decrements each clk.
//           cnt==0 and cmd_q==1 -> UP_ON.
//           cmd_q==0 -> LO_ON only if this leg came from LO_ON; otherwise reload cnt=DT-1 and go to DEAD_LO.
//      DEAD_LO: mirror of DEAD_UP.
//      UP_ON: Sxu=1, Sxl=0. cmd_q==0 -> load cnt=DT-1, go to DEAD_LO.
//      LO_ON: Sxu=0, Sxl=1. cmd_q==1 -> load cnt=DT-1, go to DEAD_UP.
//  - Abort rule: a command that reverts during dead time returns to the original ON state on the next edge.
//    This is safe because the opposite switch never turned on. Track the origin with a 1-bit prev_on register.
//  - Latency: cmd_x toggles before edge k, so cmd_q updates at edge k.
//    The old gate drops at edge k+1; the new gate rises at edge k+1+DT.
//    Exactly DT cycles with both gates 0.
//  - Pulses shorter than DT+1 clocks produce no opposite-gate pulse. This is an accepted narrowing with no error flag.
//  - Trip:
//      trip=1 sampled at edge k sets tripped at edge k; all FSMs go to OFF, so gates are 0 after edge k+1.
//      tripped holds until an edge with trip_clr=1 and trip=0; trip wins if both are asserted.
//  - en=0 forces OFF at the next edge regardless of state.
//    Re-enable always passes through a full DT dead interval before any gate turns on.
//  - Invariant, checked by assertion: never (Sxu & Sxl) on any leg, in any cycle, including across reset release.
//  - The three legs are fully independent; simultaneous commutations on all legs are legal.
// STRUCTURE
//  - Shared package: leg state encoding (OFF, DEAD_UP, DEAD_LO, UP_ON, LO_ON) as 3-bit localparams, and DT/DTW defaults.
//  - One sub-module: deadtime_leg, containing cmd_q, FSM, cnt, prev_on and the output decode.
//    Instantiated three times by deadtime_gen.
//  - deadtime_gen itself holds only the trip latch and the en/trip fan-out.
// TESTING
//  - Reset: assert res mid-run while Sau=1 -> all gates 0 immediately (async), tripped=0, stay 0 until en=1.
//  - Commutation, DT=4, en=1, cmd_a 0->1 before edge 10 -> Sal falls at edge 11; Sau rises at edge 15; edges 11-14 both 0.
//  - Abort: cmd_a 1->0 then back to 1 after 2 clks (DT=4) -> Sau low for exactly 2 clks, Sal never asserts.
//  - Trip: trip pulse 1 clk while all legs ON -> all six gates 0 the next edge and tripped=1.
//    trip_clr with trip=1 is ignored; trip_clr with trip=0 clears it, then a 4-clk dead interval precedes any gate.
//  - Enable: en 1->0->1 while cmd_b=1 -> Sbu drops the next edge; after re-enable, Sbu returns DT=4 clks later.
//  - Random: drive cmd_a/b/c from counter+spwm with random x/y/z.
//    Assert no shoot-through, every dead gap >= DT, and each gate equals the delayed command once steady.

Source files
------------

// File: rtl/deadtime_gen_pkg.sv
// Shared definitions for the three-phase dead-time generator.
package deadtime_gen_pkg;

  localparam int unsigned DT_DEF  = 4;
  localparam int unsigned DTW_DEF = 8;

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    DEAD_UP = 3'd1,
    DEAD_LO = 3'd2,
    UP_ON   = 3'd3,
    LO_ON   = 3'd4
  } leg_state_e;

endpackage

// File: rtl/deadtime_leg.sv
// One inverter leg: command register, dead-time FSM and registered gate decode.
module deadtime_leg
  import deadtime_gen_pkg::*;
#(
  parameter int unsigned DT  = DT_DEF,
  parameter int unsigned DTW = DTW_DEF
) (
  input  logic i_clk,
  input  logic i_res,
  input  logic i_en,
  input  logic i_tripped,
  input  logic i_cmd,
  output logic o_up,
  output logic o_lo
);

  localparam logic [DTW-1:0] CNT_LOAD = DTW'(DT - 1);

  logic           r_cmd_q;
  leg_state_e     r_state;
  leg_state_e     w_state_nxt;
  logic [DTW-1:0] r_cnt;
  logic [DTW-1:0] w_cnt_nxt;
  logic           r_prev_on;
  logic           w_prev_on_nxt;
  logic           r_up;
  logic           r_lo;

  // Single register stage on the comparator command.
  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) r_cmd_q <= 1'b0;
    else       r_cmd_q <= i_cmd;
  end

  // State, dead-time counter, origin flag and gate registers.
  // Gates decode the next state so they switch on the same edge as the FSM.
  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      r_state   <= OFF;
      r_cnt     <= '0;
      r_prev_on <= 1'b0;
      r_up      <= 1'b0;
      r_lo      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_prev_on <= w_prev_on_nxt;
      r_up      <= (w_state_nxt == UP_ON);
      r_lo      <= (w_state_nxt == LO_ON);
    end
  end

  // Next-state logic; r_prev_on marks a dead interval entered from the
  // opposite ON state, so a reverting command may return there at once.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_prev_on_nxt = r_prev_on;
    if (!i_en || i_tripped) begin
      w_state_nxt   = OFF;
      w_cnt_nxt     = '0;
      w_prev_on_nxt = 1'b0;
    end else begin
      case (r_state)
        OFF: begin
          w_cnt_nxt     = CNT_LOAD;
          w_prev_on_nxt = 1'b0;
          w_state_nxt   = r_cmd_q ? DEAD_UP : DEAD_LO;
        end
        DEAD_UP: begin
          if (!r_cmd_q) begin
            if (r_prev_on) begin
              w_state_nxt   = LO_ON;
              w_prev_on_nxt = 1'b0;
            end else begin
              w_state_nxt = DEAD_LO;
              w_cnt_nxt   = CNT_LOAD;
            end
          end else if (r_cnt == '0) begin
            w_state_nxt   = UP_ON;
            w_prev_on_nxt = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt - DTW'(1);
          end
        end
        DEAD_LO: begin
          if (r_cmd_q) begin
            if (r_prev_on) begin
              w_state_nxt   = UP_ON;
              w_prev_on_nxt = 1'b0;
            end else begin
              w_state_nxt = DEAD_UP;
              w_cnt_nxt   = CNT_LOAD;
            end
          end else if (r_cnt == '0) begin
            w_state_nxt   = LO_ON;
            w_prev_on_nxt = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt - DTW'(1);
          end
        end
        UP_ON: begin
          if (!r_cmd_q) begin
            w_state_nxt   = DEAD_LO;
            w_cnt_nxt     = CNT_LOAD;
            w_prev_on_nxt = 1'b1;
          end
        end
        LO_ON: begin
          if (r_cmd_q) begin
            w_state_nxt   = DEAD_UP;
            w_cnt_nxt     = CNT_LOAD;
            w_prev_on_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt   = OFF;
          w_cnt_nxt     = '0;
          w_prev_on_nxt = 1'b0;
        end
      endcase
    end
  end

  assign o_up = r_up;
  assign o_lo = r_lo;

endmodule

// File: rtl/deadtime_gen.sv
// Three-phase dead-time insertion with enable gating and latched over-current trip.
module deadtime_gen
  import deadtime_gen_pkg::*;
#(
  parameter int unsigned DT  = DT_DEF,
  parameter int unsigned DTW = DTW_DEF
) (
  input  logic clk,
  input  logic res,
  input  logic en,
  input  logic trip,
  input  logic trip_clr,
  input  logic cmd_a,
  input  logic cmd_b,
  input  logic cmd_c,
  output logic Sau,
  output logic Sal,
  output logic Sbu,
  output logic Sbl,
  output logic Scu,
  output logic Scl,
  output logic tripped
);

  logic r_tripped;

  // Trip latch: trip sets, trip_clr clears only while trip is low.
  always_ff @(posedge clk or posedge res) begin
    if (res)           r_tripped <= 1'b0;
    else if (trip)     r_tripped <= 1'b1;
    else if (trip_clr) r_tripped <= 1'b0;
  end

  assign tripped = r_tripped;

  deadtime_leg #(.DT(DT), .DTW(DTW)) u_leg_a (
    .i_clk(clk), .i_res(res), .i_en(en), .i_tripped(r_tripped),
    .i_cmd(cmd_a), .o_up(Sau), .o_lo(Sal)
  );

  deadtime_leg #(.DT(DT), .DTW(DTW)) u_leg_b (
    .i_clk(clk), .i_res(res), .i_en(en), .i_tripped(r_tripped),
    .i_cmd(cmd_b), .o_up(Sbu), .o_lo(Sbl)
  );

  deadtime_leg #(.DT(DT), .DTW(DTW)) u_leg_c (
    .i_clk(clk), .i_res(res), .i_en(en), .i_tripped(r_tripped),
    .i_cmd(cmd_c), .o_up(Scu), .o_lo(Scl)
  );

endmodule

// File: tb/tb_deadtime_gen.sv
// Bench for deadtime_gen: directed table, corner sequences and randomized
// stimulus against a side/run-length reference model.
module tb_deadtime_gen;

  localparam int unsigned DT = 4;

  logic clk, res, en, trip, trip_clr;
  logic [2:0] cmd;
  logic Sau, Sal, Sbu, Sbl, Scu, Scl, tripped;
  logic [6:0] w_act;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  deadtime_gen #(.DT(DT), .DTW(8)) dut (
    .clk(clk), .res(res), .en(en), .trip(trip), .trip_clr(trip_clr),
    .cmd_a(cmd[0]), .cmd_b(cmd[1]), .cmd_c(cmd[2]),
    .Sau(Sau), .Sal(Sal), .Sbu(Sbu), .Sbl(Sbl), .Scu(Scu), .Scl(Scl),
    .tripped(tripped)
  );

  // {tripped, Scl, Scu, Sbl, Sbu, Sal, Sau}
  assign w_act = {tripped, Scl, Scu, Sbl, Sbu, Sal, Sau};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a leg's gate for value v is on when v is the side
  // already conducting, or v has been held for DT+1 enabled edges.
  int unsigned m_side[3];   // 0 none, 1 upper, 2 lower
  int unsigned m_run[3];
  logic        m_cq[3], m_lastc[3], m_up[3], m_lo[3];
  logic        m_trip;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_side[i] = 0; m_run[i] = 0;
      m_cq[i] = 1'b0; m_lastc[i] = 1'b0; m_up[i] = 1'b0; m_lo[i] = 1'b0;
    end
    m_trip = 1'b0;
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      logic c;
      int unsigned want;
      c = m_cq[i];
      if (!en || m_trip) begin
        m_side[i] = 0; m_run[i] = 0; m_up[i] = 1'b0; m_lo[i] = 1'b0;
      end else begin
        m_run[i] = (m_run[i] != 0 && c == m_lastc[i]) ? m_run[i] + 1 : 1;
        want = c ? 1 : 2;
        if (m_side[i] != want && m_run[i] >= DT + 1) m_side[i] = want;
        m_up[i] = (m_side[i] == want) && c;
        m_lo[i] = (m_side[i] == want) && !c;
      end
      m_lastc[i] = c;
      m_cq[i] = cmd[i];
    end
    if (trip)          m_trip = 1'b1;
    else if (trip_clr) m_trip = 1'b0;
  endtask

  function automatic logic [6:0] model_outs();
    return {m_trip, m_lo[2], m_up[2], m_lo[1], m_up[1], m_lo[0], m_up[0]};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (tripped,Scl,Scu,Sbl,Sbu,Sal,Sau)", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input string name);
    model_edge();
    @(posedge clk);
    #1;
    check(name, w_act, model_outs());
  endtask

  // Shoot-through assertion and minimum dead gap between opposite gates.
  int unsigned g_zero[3] = '{0, 0, 0};
  int unsigned g_last[3] = '{0, 0, 0};
  always @(negedge clk) begin
    logic [2:0] up, lo;
    up = {Scu, Sbu, Sau};
    lo = {Scl, Sbl, Sal};
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      assert (!(up[i] && lo[i])) else begin
        n_err++;
        $display("FAIL shoot_through leg%0d: up=%b lo=%b, required not both 1", i, up[i], lo[i]);
      end
      if (up[i] || lo[i]) begin
        int unsigned side;
        side = up[i] ? 1 : 2;
        if (g_last[i] != 0 && g_last[i] != side) begin
          n_cmp++;
          if (g_zero[i] < DT) begin
            n_err++;
            $display("FAIL dead_gap leg%0d: got %0d, required >= %0d", i, g_zero[i], DT);
          end
        end
        g_last[i] = side;
        g_zero[i] = 0;
      end else begin
        g_zero[i]++;
      end
    end
  end

  typedef struct {
    logic [2:0] cmd;
    logic       en;
    logic       trip;
    logic       clr;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[33];

  task automatic pulse_a(input int unsigned len, input int unsigned exp_low, input int unsigned exp_sal);
    int unsigned low_cnt, sal_cnt;
    low_cnt = 0; sal_cnt = 0;
    cmd[0] = 1'b0;
    repeat (len) begin
      tick("pulse_step");
      if (!Sau) low_cnt++;
      if (Sal)  sal_cnt++;
    end
    cmd[0] = 1'b1;
    repeat (14) begin
      tick("pulse_step");
      if (!Sau) low_cnt++;
      if (Sal)  sal_cnt++;
    end
    check_int($sformatf("pulse%0d_sau_low", len), low_cnt, exp_low);
    check_int($sformatf("pulse%0d_sal_high", len), sal_cnt, exp_sal);
  endtask

  initial begin
    int unsigned car;
    int unsigned refv[3];
    int unsigned hold[3];

    vecs[0]  = '{3'b101, 1'b0, 1'b0, 1'b0, 7'b0000000};
    vecs[1]  = '{3'b101, 1'b1, 1'b0, 1'b0, 7'b0000000};
    vecs[2]  = '{3'b101, 1'b1, 1'b0, 1'b0, 7'b0000000};
    vecs[3]  = '{3'b101, 1'b1, 1'b0, 1'b0, 7'b0000000};
    vecs[4]  = '{3'b101, 1'b1, 1'b0, 1'b0, 7'b0000000};
    vecs[5]  = '{3'b101, 1'b1, 1'b0, 1'b0, 7'b0011001};
    vecs[6]  = '{3'b100, 1'b1, 1'b0, 1'b0, 7'b0011001};
    vecs[7]  = '{3'b100, 1'b1, 1'b0, 1'b0, 7'b0011000};
    vecs[8]  = '{3'b100, 1'b1, 1'b0, 1'b0, 7'b0011000};
    vecs[9]  = '{3'b100, 1'b1, 1'b0, 1'b0, 7'b0011000};
    vecs[10] = '{3'b100, 1'b1, 1'b0, 1'b0, 7'b0011000};
    vecs[11] = '{3'b100, 1'b1, 1'b0, 1'b0, 7'b0011010};
    vecs[12] = '{3'b100, 1'b1, 1'b1, 1'b0, 7'b1011010};
    vecs[13] = '{3'b100, 1'b1, 1'b0, 1'b0, 7'b1000000};
    vecs[14] = '{3'b100, 1'b1, 1'b1, 1'b1, 7'b1000000};
    vecs[15] = '{3'b100, 1'b1, 1'b0, 1'b1, 7'b0000000};
    vecs[16] = '{3'b100, 1'b1, 1'b0, 1'b0, 7'b0000000};
    vecs[17] = '{3'b100, 1'b1, 1'b0, 1'b0, 7'b0000000};
    vecs[18] = '{3'b100, 1'b1, 1'b0, 1'b0, 7'b0000000};
    vecs[19] = '{3'b100, 1'b1, 1'b0, 1'b0, 7'b0000000};
    vecs[20] = '{3'b100, 1'b1, 1'b0, 1'b0, 7'b0011010};
    vecs[21] = '{3'b110, 1'b0, 1'b0, 1'b0, 7'b0000000};
    vecs[22] = '{3'b110, 1'b1, 1'b0, 1'b0, 7'b0000000};
    vecs[23] = '{3'b110, 1'b1, 1'b0, 1'b0, 7'b0000000};
    vecs[24] = '{3'b110, 1'b1, 1'b0, 1'b0, 7'b0000000};
    vecs[25] = '{3'b110, 1'b1, 1'b0, 1'b0, 7'b0000000};
    vecs[26] = '{3'b110, 1'b1, 1'b0, 1'b0, 7'b0010110};
    vecs[27] = '{3'b110, 1'b0, 1'b0, 1'b0, 7'b0000000};
    vecs[28] = '{3'b110, 1'b1, 1'b0, 1'b0, 7'b0000000};
    vecs[29] = '{3'b110, 1'b1, 1'b0, 1'b0, 7'b0000000};
    vecs[30] = '{3'b110, 1'b1, 1'b0, 1'b0, 7'b0000000};
    vecs[31] = '{3'b110, 1'b1, 1'b0, 1'b0, 7'b0000000};
    vecs[32] = '{3'b110, 1'b1, 1'b0, 1'b0, 7'b0010110};

    res = 1'b1; en = 1'b0; trip = 1'b0; trip_clr = 1'b0; cmd = 3'b000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", w_act, 7'b0000000);
    res = 1'b0;

    // Directed table: commutation, trip/clear, enable drop.
    for (int i = 0; i < 33; i++) begin
      cmd = vecs[i].cmd; en = vecs[i].en; trip = vecs[i].trip; trip_clr = vecs[i].clr;
      tick("table_model");
      check($sformatf("table_row%0d", i + 1), w_act, vecs[i].exp);
    end
    trip = 1'b0; trip_clr = 1'b0;

    // Pulse narrowing and abort on leg a.
    cmd = 3'b111; en = 1'b1;
    repeat (12) tick("settle");
    check("settled_all_upper", w_act, 7'b0010101);
    pulse_a(2, 2, 0);
    pulse_a(DT, DT, 0);
    pulse_a(DT + 1, 2 * DT + 1, 1);

    // Asynchronous reset mid-cycle with gates on.
    check("pre_reset_on", w_act, 7'b0010101);
    #3;
    res = 1'b1;
    #1;
    check("async_reset_immediate", w_act, 7'b0000000);
    model_reset();
    @(posedge clk);
    #1;
    check("reset_held", w_act, 7'b0000000);
    en = 1'b0;
    res = 1'b0;
    repeat (3) begin
      tick("post_reset_en0");
      check("post_reset_stays_off", w_act, 7'b0000000);
    end
    en = 1'b1;
    repeat (DT) tick("reenable_dead");
    check("reenable_still_dead", w_act, 7'b0000000);
    tick("reenable_on");
    check("reenable_on", w_act, 7'b0010101);

    // SPWM-like random stimulus: triangle carrier against random references.
    for (int t = 0; t < 1600; t++) begin
      if (t % 32 == 0)
        for (int i = 0; i < 3; i++) refv[i] = $urandom_range(0, 16);
      car = (t % 32 < 16) ? (t % 32) : (31 - t % 32);
      for (int i = 0; i < 3; i++) cmd[i] = (refv[i] > car);
      en       = ($urandom_range(0, 149) != 0);
      trip     = ($urandom_range(0, 299) == 0);
      trip_clr = ($urandom_range(0, 19) == 0);
      tick("spwm_random");
    end

    // Independent random toggles with holds around the dead time.
    for (int i = 0; i < 3; i++) hold[i] = 1;
    trip = 1'b0; trip_clr = 1'b1; en = 1'b1;
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < 3; i++) begin
        hold[i]--;
        if (hold[i] == 0) begin
          cmd[i] = ~cmd[i];
          hold[i] = $urandom_range(1, 2 * DT + 2);
        end
      end
      trip_clr = ($urandom_range(0, 3) == 0);
      trip     = ($urandom_range(0, 399) == 0);
      tick("toggle_random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
